// File: rtl/fifo_push_arbiter_if.sv
// Push-side bus of fifo_push_arbiter: requester valid/data/grant, FIFO push handshake and status.
// The arbiter takes the slave view; producers plus FIFO (or a bench) take the master view.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int DW1   = DATA_WIDTH + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ*DW1-1:0] req_data_i;
  logic [NUM_REQ-1:0]     req_grant_o;
  logic [DW1-1:0]         fifo_data_o;
  logic                   fifo_valid_o;
  logic                   fifo_grant_i;
  logic [IDX_W-1:0]       owner_o;
  logic                   busy_o;
  logic [7:0]             drop_cnt_o;

  modport master (
    output req_valid_i, req_data_i, fifo_grant_i,
    input  req_grant_o, fifo_data_o, fifo_valid_o, owner_o, busy_o, drop_cnt_o
  );

  modport slave (
    input  req_valid_i, req_data_i, fifo_grant_i,
    output req_grant_o, fifo_data_o, fifo_valid_o, owner_o, busy_o, drop_cnt_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO push port among NUM_REQ requesters.
// Optional parity-drop of corrupt beats is enabled by defining FIFO_ARB_PARITY_DROP_EN.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_push_arbiter_if.slave bus
);
  localparam int DW1   = DATA_WIDTH + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [7:0]         beat_cnt;

  logic               owner_valid;
  logic [DW1-1:0]     owner_data;
  logic               corrupt;
  logic               fwd_valid;
  logic               xfer;
  logic               last_beat;
  logic               rel_burst;
  logic               any_req;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [2*NUM_REQ-2:0] req_dbl;
  logic [NUM_REQ-1:0] req_rot;

  // Index arithmetic modulo NUM_REQ; operands never exceed 2*NUM_REQ-2.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] s);
    if (s >= (IDX_W+1)'(NUM_REQ))
      return IDX_W'(s - (IDX_W+1)'(NUM_REQ));
    else
      return s[IDX_W-1:0];
  endfunction

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        owner_valid = bus.req_valid_i[k];
        owner_data  = bus.req_data_i[k*DW1 +: DW1];
      end
    end
  end

  // Rotating the request vector by rr_ptr turns the wrap-around scan into a plain lowest-bit search.
  assign req_dbl = {bus.req_valid_i[NUM_REQ-2:0], bus.req_valid_i};
  assign req_rot = req_dbl[rr_ptr +: NUM_REQ];
  assign any_req = |bus.req_valid_i;

  always_comb begin
    pick_idx = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_idx = wrap_idx({1'b0, rr_ptr} + (IDX_W+1)'(i));
    end
  end

  assign next_ptr = wrap_idx({1'b0, owner} + (IDX_W+1)'(1));

`ifdef FIFO_ARB_PARITY_DROP_EN
  assign corrupt = (state == BUSY) & owner_valid & (^owner_data);
`else
  assign corrupt = 1'b0;
`endif

  assign fwd_valid = (state == BUSY) & owner_valid & ~corrupt;
  assign xfer      = fwd_valid & bus.fifo_grant_i;
  assign last_beat = xfer & (({1'b0, beat_cnt} + 9'd1) == 9'(BURST_LEN));
  assign rel_burst = last_beat | ~owner_valid;

  // A corrupt beat is granted unconditionally so the producer retires it without reaching the FIFO.
  always_comb begin
    bus.req_grant_o  = '0;
    bus.fifo_valid_o = 1'b0;
    bus.fifo_data_o  = '0;
    if (state == BUSY) begin
      bus.fifo_valid_o = fwd_valid;
      bus.fifo_data_o  = owner_data;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner == IDX_W'(k)) bus.req_grant_o[k] = bus.fifo_grant_i | corrupt;
      end
    end
  end

  assign bus.owner_o = owner;
  assign bus.busy_o  = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) beat_cnt <= beat_cnt + 8'd1;
          if (rel_burst) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_PARITY_DROP_EN
  logic [7:0] drop_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          drop_cnt <= '0;
    else if (corrupt) drop_cnt <= sat_inc8(drop_cnt);
  end

  assign bus.drop_cnt_o = drop_cnt;
`else
  assign bus.drop_cnt_o = 8'd0;
`endif

endmodule
